ej32_div_seq: RTL and testbench

EJ32_DIV_SEQ -- requirements
Module: ej32_div_seq

---
 rtl/ej32_div_seq.sv | 125 ++++++++++++
 tb/tb_ej32_div_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ej32_div_seq.sv
// Sequential signed divider (restoring, one quotient bit per cycle) for the EJ32 AU.
// Produces Java idiv/irem results: quotient truncates toward zero, remainder follows the dividend.
module ej32_div_seq #(
    parameter int DSZ = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic signed [DSZ-1:0] x,
    input  logic signed [DSZ-1:0] y,
    output logic                  busy,
    output logic                  done,
    output logic                  z,
    output logic signed [DSZ-1:0] q,
    output logic signed [DSZ-1:0] r
);

    localparam int CW = (DSZ > 1) ? $clog2(DSZ) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [DSZ-1:0] rem_q;
    logic [DSZ-1:0] quo_q;
    logic [DSZ-1:0] div_q;
    logic           sx_q;
    logic           sq_q;
    logic           busy_q;
    logic           done_q;
    logic           z_q;
    logic [DSZ-1:0] q_q;
    logic [DSZ-1:0] r_q;

    logic [DSZ:0]   diff_d;
    logic [DSZ-1:0] rem_d;
    logic [DSZ-1:0] quo_d;

    function automatic logic [DSZ-1:0] mag(input logic [DSZ-1:0] v);
        return v[DSZ-1] ? -v : v;
    endfunction

    function automatic logic [DSZ-1:0] neg_if(input logic [DSZ-1:0] v, input logic s);
        return s ? -v : v;
    endfunction

    // quo_q starts as |x| and shifts left, so its MSB feeds the remainder while
    // freshly decided quotient bits enter at the LSB.
    always_comb begin
        diff_d = {rem_q, quo_q[DSZ-1]} - {1'b0, div_q};
        if (!diff_d[DSZ]) begin
            rem_d = diff_d[DSZ-1:0];
            quo_d = {quo_q[DSZ-2:0], 1'b1};
        end else begin
            rem_d = {rem_q[DSZ-2:0], quo_q[DSZ-1]};
            quo_d = {quo_q[DSZ-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            sx_q    <= 1'b0;
            sq_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            z_q     <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (y == '0) begin
                            // Divide-by-zero completes immediately without entering CALC.
                            z_q    <= 1'b1;
                            q_q    <= '0;
                            r_q    <= x;
                            done_q <= 1'b1;
                        end else begin
                            quo_q   <= mag(x);
                            div_q   <= mag(y);
                            sx_q    <= x[DSZ-1];
                            sq_q    <= x[DSZ-1] ^ y[DSZ-1];
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            z_q     <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(DSZ - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    // MIN / -1 wraps back to MIN here, matching Java.
                    q_q     <= neg_if(quo_q, sq_q);
                    r_q     <= neg_if(rem_q, sx_q);
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign z    = z_q;
    assign q    = q_q;
    assign r    = r_q;

endmodule

// File: tb/tb_ej32_div_seq.sv
// Directed and table-driven bench for ej32_div_seq (DSZ=32), with a small signed reference model.
module tb_ej32_div_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] x;
    logic [31:0] y;
    logic        busy;
    logic        done;
    logic        z;
    logic [31:0] q;
    logic [31:0] r;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eq;
        logic [31:0] er;
        logic        ez;
        int          lat;
    } vec_t;

    vec_t tbl [17];

    ej32_div_seq #(.DSZ(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .z     (z),
        .q     (q),
        .r     (r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done was seen (or after the budget).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eq,
                          input logic [31:0] er, input logic ez, input int lat, input string nm);
        int c;
        bit seen;
        bit busy_ok;
        x = a;
        y = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        x = ~a;
        y = b + 32'd1;
        seen = 0;
        busy_ok = 1;
        c = 0;
        while (!seen && c < 40) begin
            @(negedge clk);
            c++;
            if (busy !== (c < lat)) busy_ok = 0;
            if (done === 1'b1) seen = 1;
        end
        check({nm, " latency"}, seen ? 32'(c) : 32'hFFFFFFFF, 32'(lat));
        check({nm, " q"}, q, eq);
        check({nm, " r"}, r, er);
        check({nm, " z"}, {31'd0, z}, {31'd0, ez});
        check({nm, " busy window"}, {31'd0, busy_ok}, 32'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h8000_0000;
            5:       return 32'($urandom_range(0, 20)) - 32'd10;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int c;
        int ndone;
        bit seen;
        logic [31:0] a, b, eq, er;
        logic ez;
        int lat;
        int sa, sb;

        tbl[0]  = '{32'd7,        32'd2,        32'd3,        32'd1,        1'b0, 34};
        tbl[1]  = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34};
        tbl[2]  = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 34};
        tbl[3]  = '{32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0, 34};
        tbl[4]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 34};
        tbl[5]  = '{32'h80000000, 32'd1,        32'h80000000, 32'd0,        1'b0, 34};
        tbl[6]  = '{32'h00001234, 32'd0,        32'd0,        32'h00001234, 1'b1, 1};
        tbl[7]  = '{32'd9,        32'd3,        32'd3,        32'd0,        1'b0, 34};
        tbl[8]  = '{32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 34};
        tbl[9]  = '{32'd0,        32'd5,        32'd0,        32'd0,        1'b0, 34};
        tbl[10] = '{32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 32'd0,        1'b0, 34};
        tbl[11] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'd0,        32'hFFFFFFFF, 1'b0, 34};
        tbl[12] = '{32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 34};
        tbl[13] = '{32'd5,        32'd7,        32'd0,        32'd5,        1'b0, 34};
        tbl[14] = '{32'h80000000, 32'd2,        32'hC0000000, 32'd0,        1'b0, 34};
        tbl[15] = '{32'hFFFFFFFF, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b1, 1};
        tbl[16] = '{32'h12345678, 32'd1000,     32'h0004A90B, 32'h00000380, 1'b0, 34};

        rst = 1'b0;
        start = 1'b0;
        x = '0;
        y = '0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset z", {31'd0, z}, 32'd0);
        check("reset q", q, 32'd0);
        check("reset r", r, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].eq, tbl[i].er, tbl[i].ez, tbl[i].lat,
                   $sformatf("vec%0d", i));
        end

        // start pulsed while busy must not disturb 100/7
        x = 32'd100;
        y = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        x = '0;
        y = '0;
        seen = 0;
        c = 0;
        while (!seen && c < 40) begin
            @(negedge clk);
            c++;
            if (c == 10) begin
                start = 1'b1;
                x = 32'd5;
                y = 32'd1;
            end else if (c == 11) begin
                start = 1'b0;
            end
            if (done === 1'b1) seen = 1;
        end
        check("ignore latency", seen ? 32'(c) : 32'hFFFFFFFF, 32'd34);
        check("ignore q", q, 32'd14);
        check("ignore r", r, 32'd2);
        check("ignore z", {31'd0, z}, 32'd0);

        // asynchronous reset in the middle of a run
        x = 32'd50;
        y = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("midop busy before rst", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        check("midop rst busy", {31'd0, busy}, 32'd0);
        check("midop rst done", {31'd0, done}, 32'd0);
        check("midop rst z", {31'd0, z}, 32'd0);
        check("midop rst q", q, 32'd0);
        check("midop rst r", r, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        check("midop no done after abort", 32'(ndone), 32'd0);
        run_op(32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 34, "post-reset 7/2");

        // start held high: accepted again in each done cycle
        x = 32'hFFFFFF9C;
        y = 32'd9;
        start = 1'b1;
        ndone = 0;
        for (int i = 1; i <= 110; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                check($sformatf("b2b done%0d cycle", ndone), 32'(i), 32'(34 * ndone));
                check($sformatf("b2b done%0d q", ndone), q, 32'hFFFFFFF5);
                check($sformatf("b2b done%0d r", ndone), r, 32'hFFFFFFFF);
            end
        end
        start = 1'b0;
        check("b2b done count", 32'(ndone), 32'd3);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        check("b2b drain", {31'd0, seen}, 32'd1);

        for (int i = 0; i < 250; i++) begin
            a = pick();
            b = pick();
            ez = 1'b0;
            lat = 34;
            if (b == 32'd0) begin
                eq = 32'd0;
                er = a;
                ez = 1'b1;
                lat = 1;
            end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                eq = a;
                er = 32'd0;
            end else begin
                sa = a;
                sb = b;
                eq = sa / sb;
                er = sa % sb;
            end
            run_op(a, b, eq, er, ez, lat, $sformatf("rand%0d %h/%h", i, a, b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
